// File: rtl/cpu6_alu_arb.sv
// rtl/cpu6_alu_arb.sv - two-requester arbiter in front of a shared combinational ALU with a one-entry result buffer
// Optional feature: define CPU6_ALU_ARB_RR_EN for round-robin arbitration (default: req0 fixed priority).

`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif

`ifndef CPU6_ALU_CONTROL_SIZE
`define CPU6_ALU_CONTROL_SIZE 3
`endif

module cpu6_alu_arb (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              req0_valid,
  output logic                              req0_ready,
  input  logic [`CPU6_XLEN-1:0]             req0_a,
  input  logic [`CPU6_XLEN-1:0]             req0_b,
  input  logic [`CPU6_ALU_CONTROL_SIZE-1:0] req0_control,
  input  logic                              req1_valid,
  output logic                              req1_ready,
  input  logic [`CPU6_XLEN-1:0]             req1_a,
  input  logic [`CPU6_XLEN-1:0]             req1_b,
  input  logic [`CPU6_ALU_CONTROL_SIZE-1:0] req1_control,
  output logic [`CPU6_XLEN-1:0]             alu_a,
  output logic [`CPU6_XLEN-1:0]             alu_b,
  output logic [`CPU6_ALU_CONTROL_SIZE-1:0] alu_control,
  input  logic [`CPU6_XLEN-1:0]             alu_y,
  input  logic                              alu_zero,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_id,
  output logic [`CPU6_XLEN-1:0]             rsp_y,
  output logic                              rsp_zero
);

  localparam int XLEN = `CPU6_XLEN;
  localparam int CW   = `CPU6_ALU_CONTROL_SIZE;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   rsp_y_q, rsp_y_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_id_q, rsp_id_d;

  logic              slot_free;
  logic              grant0;
  logic              grant1;
  logic              grant_any;
  logic              grant_idx;
  logic              drain;

`ifdef CPU6_ALU_ARB_RR_EN
  logic              last_grant_q, last_grant_d;
`endif

  // The buffer can take a new result when it is empty or being emptied this cycle
  always_comb begin
    slot_free = (state_q == ST_EMPTY) | rsp_ready;
    drain     = (state_q == ST_FULL) & rsp_ready;
  end

  // Pick at most one requester; grants are suppressed while reset is held so
  // nothing is handed out before the buffer state is trustworthy
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (resetn && slot_free) begin
`ifdef CPU6_ALU_ARB_RR_EN
      if (req0_valid && req1_valid) begin
        // Contention: alternate away from whoever won last
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
`else
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
`endif
    end
    grant_any  = grant0 | grant1;
    grant_idx  = grant1;
    req0_ready = grant0;
    req1_ready = grant1;
  end

  // Steer the winner's operands to the shared ALU; idle cycles present zeros
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = '0;
    if (grant0) begin
      alu_a       = req0_a;
      alu_b       = req0_b;
      alu_control = req0_control;
    end else if (grant1) begin
      alu_a       = req1_a;
      alu_b       = req1_b;
      alu_control = req1_control;
    end
  end

  // Buffer next state: a grant always (re)loads, a drain without grant empties,
  // otherwise the held response stays put
  always_comb begin
    state_d    = state_q;
    rsp_y_d    = rsp_y_q;
    rsp_zero_d = rsp_zero_q;
    rsp_id_d   = rsp_id_q;
    if (grant_any) begin
      state_d    = ST_FULL;
      rsp_y_d    = alu_y;
      rsp_zero_d = alu_zero;
      rsp_id_d   = grant_idx;
    end else if (drain) begin
      state_d    = ST_EMPTY;
    end
  end

`ifdef CPU6_ALU_ARB_RR_EN
  // Remember the most recent winner for the alternation rule
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_any) begin
      last_grant_d = grant_idx;
    end
  end
`endif

  // Single register stage; reset leaves last_grant at 1 so req0 wins the first contention
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_EMPTY;
      rsp_y_q      <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
`ifdef CPU6_ALU_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      rsp_y_q      <= rsp_y_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_id_q     <= rsp_id_d;
`ifdef CPU6_ALU_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Response outputs come straight from flops
  always_comb begin
    rsp_valid = (state_q == ST_FULL);
    rsp_y     = rsp_y_q;
    rsp_zero  = rsp_zero_q;
    rsp_id    = rsp_id_q;
  end

endmodule

// File: tb/tb_cpu6_alu_arb.sv
// tb/tb_cpu6_alu_arb.sv - scoreboard bench for cpu6_alu_arb with a behavioural ALU

`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif

`ifndef CPU6_ALU_CONTROL_SIZE
`define CPU6_ALU_CONTROL_SIZE 3
`endif

module tb_cpu6_alu_arb;

  localparam int XLEN = `CPU6_XLEN;
  localparam int CW   = `CPU6_ALU_CONTROL_SIZE;

  typedef struct packed {
    logic            id;
    logic [XLEN-1:0] y;
    logic            zero;
  } exp_t;

  logic            clk = 1'b0;
  logic            resetn;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [CW-1:0]   req0_control, req1_control;
  logic [XLEN-1:0] alu_a, alu_b, alu_y;
  logic [CW-1:0]   alu_control;
  logic            alu_zero;
  logic            rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [XLEN-1:0] rsp_y;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  logic accepted_prev = 1'b0;

  always #5 clk = ~clk;

  // Reference ALU: add 010, sub 110, anything else yields y=0 zero=0
  logic alu_known;
  assign alu_known = (alu_control == 3'b010) || (alu_control == 3'b110);
  assign alu_y     = (alu_control == 3'b010) ? alu_a + alu_b :
                     (alu_control == 3'b110) ? alu_a - alu_b : '0;
  assign alu_zero  = alu_known && (alu_y == '0);

  cpu6_alu_arb dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_control(req0_control),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_control(req1_control),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_y(alu_y), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_zero(rsp_zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [XLEN-1:0] a0, input logic [XLEN-1:0] b0,
                       input logic [CW-1:0] c0, input logic v1, input logic [XLEN-1:0] a1,
                       input logic [XLEN-1:0] b1, input logic [CW-1:0] c1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_control = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_control = c1;
  endtask

  task automatic push(input logic id, input logic [XLEN-1:0] y, input logic zero);
    exp_t e;
    e.id = id; e.y = y; e.zero = zero;
    sb_q.push_back(e);
  endtask

  // Monitor: latency check one cycle after each accept, and scoreboard pop on every drain
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      accepted_prev <= 1'b0;
    end else begin
      if (accepted_prev) chk("latency_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_id_y_zero", {29'd0, rsp_id, rsp_y, rsp_zero}, {29'd0, e.id, e.y, e.zero});
        end
      end
      accepted_prev <= (req0_valid & req0_ready) | (req1_valid & req1_ready);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int ids[4];
  logic eid;

  initial begin
`ifdef CPU6_ALU_ARB_RR_EN
    ids = '{0, 1, 0, 1};
    eid = 1'b1;
`else
    ids = '{0, 0, 0, 0};
    eid = 1'b0;
`endif
    resetn    = 1'b0;
    rsp_ready = 1'b1;
    drive(1, 32'd5, 32'd7, 3'b010, 1, 32'd9, 32'd9, 3'b110);
    #3;
    chk("reset_readys", {62'd0, req0_ready, req1_ready}, 64'd0);
    chk("reset_alu", {alu_a, alu_b[XLEN-1:CW], alu_control}, 64'd0);
    chk("reset_rsp", {29'd0, rsp_valid, rsp_id, rsp_zero, rsp_y}, 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    resetn = 1'b1;
    cyc();

    // Add from req0
    drive(1, 32'd5, 32'd7, 3'b010, 0, 0, 0, 0);
    #2;
    chk("add_readys", {62'd0, req0_ready, req1_ready}, 64'd2);
    chk("add_alu_ops", {alu_a, alu_b}, {32'd5, 32'd7});
    push(1'b0, 32'd12, 1'b0);
    cyc();

    // Sub from req1 giving zero
    drive(0, 0, 0, 0, 1, 32'd9, 32'd9, 3'b110);
    #2;
    chk("sub_readys", {62'd0, req0_ready, req1_ready}, 64'd1);
    push(1'b1, 32'd0, 1'b1);
    cyc();

    // Contention for 4 cycles
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'd1, 32'd2, 3'b010, 1, 32'd10, 32'd4, 3'b110);
      #2;
      chk("both_readys", {62'd0, req0_ready, req1_ready},
          (ids[k] == 0) ? 64'd2 : 64'd1);
      push(ids[k][0], (ids[k] == 0) ? 32'd3 : 32'd6, 1'b0);
      cyc();
    end

    // Idle presents zeros to the ALU
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("idle_alu", {alu_a, alu_b[XLEN-1:CW], alu_control}, 64'd0);
    cyc();

    // Backpressure
    rsp_ready = 1'b0;
    drive(1, 32'd20, 32'd22, 3'b010, 0, 0, 0, 0);
    #2;
    chk("bp_accept", {62'd0, req0_ready, req1_ready}, 64'd2);
    push(1'b0, 32'd42, 1'b0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'd3, 32'd4, 3'b010, 1, 32'd8, 32'd1, 3'b110);
      #2;
      chk("bp_readys", {62'd0, req0_ready, req1_ready}, 64'd0);
      chk("bp_hold", {31'd0, rsp_valid, rsp_y}, {31'd0, 1'b1, 32'd42});
      cyc();
    end
    rsp_ready = 1'b1;
    #2;
    chk("bp_release_readys", {62'd0, req0_ready, req1_ready}, eid ? 64'd1 : 64'd2);
    push(eid, 32'd7, 1'b0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("bp_reload", {30'd0, rsp_valid, rsp_id, rsp_y}, {30'd0, 1'b1, eid, 32'd7});
    cyc();
    #2;
    chk("drain_empty", {63'd0, rsp_valid}, 64'd0);
    cyc();

    // Unknown control code
    drive(1, 32'd5, 32'd3, 3'b111, 0, 0, 0, 0);
    #2;
    chk("unk_alu_control", {61'd0, alu_control}, 64'd7);
    push(1'b0, 32'd0, 1'b0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("unk_idle_control", {61'd0, alu_control}, 64'd0);
    cyc();

    // Asynchronous reset while FULL
    rsp_ready = 1'b0;
    drive(1, 32'd1, 32'd1, 3'b010, 0, 0, 0, 0);
    #2;
    chk("rst_pre_accept", {63'd0, req0_ready}, 64'd1);
    push(1'b0, 32'd2, 1'b0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_pre_full", {63'd0, rsp_valid}, 64'd1);
    resetn = 1'b0;
    #1;
    chk("rst_async_clear", {29'd0, rsp_valid, rsp_id, rsp_zero, rsp_y}, 64'd0);
    sb_q.delete();
    drive(1, 32'd2, 32'd2, 3'b010, 1, 32'd7, 32'd7, 3'b110);
    #1;
    chk("rst_hold_readys", {59'd0, req0_ready, req1_ready, alu_control}, 64'd0);
    cyc();
    resetn    = 1'b1;
    rsp_ready = 1'b1;
    #2;
    chk("post_rst_first_grant", {62'd0, req0_ready, req1_ready}, 64'd2);
    push(1'b0, 32'd4, 1'b0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    chk("sb_empty", sb_q.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu6_alu_arb.md
CPU6_ALU_ARB -- requirements
Module: cpu6_alu_arb

Interface
REQ-001 SHALL take its widths from these global defines (name, default, meaning):
- CPU6_XLEN, codebase global value, operand/result width (XLEN).
- CPU6_ALU_CONTROL_SIZE, 3, ALU control code width (CW).
REQ-002 SHALL use one clock and an asynchronous, active-low reset. Ports (name  direction  width  meaning):
- clk  in  1  single clock, all state updates on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  XLEN  requester 0 operands.
- req0_control  in  CW  requester 0 ALU code (add 010, sub 110).
- req1_valid, req1_ready, req1_a, req1_b, req1_control  same widths and meaning, requester 1.
- alu_a, alu_b  out  XLEN  operands to shared ALU.
- alu_control  out  CW  code to shared ALU.
- alu_y  in  XLEN  ALU result (combinational).
- alu_zero  in  1  ALU zero flag (combinational).
- rsp_valid  out  1  result buffer holds a response.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_id  out  1  requester that owns the response.
- rsp_y  out  XLEN  captured result.
- rsp_zero  out  1  captured zero flag.

Function
REQ-003 SHALL hold a single-entry result buffer with two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-004 SHALL compute slot_free = !rsp_valid | rsp_ready.
REQ-005 SHALL grant at most one requester per cycle, and only when slot_free=1 and that requester's valid=1.
REQ-006 SHALL drive reqN_ready combinationally equal to grantN; acceptance occurs when reqN_valid and reqN_ready are both 1.
REQ-007 SHALL drive alu_a/alu_b/alu_control from the granted requester in the grant cycle; with no grant, all three SHALL be 0.
REQ-008 SHALL, on the edge closing a grant cycle, capture alu_y→rsp_y, alu_zero→rsp_zero and the grant index→rsp_id, and set rsp_valid=1. Latency from accept to rsp_valid is exactly 1 cycle.
REQ-009 SHALL clear rsp_valid on a drain (rsp_valid & rsp_ready) with no simultaneous grant.
REQ-010 SHALL, on a drain with a simultaneous grant, load the new response and keep rsp_valid=1 (sustained throughput 1 op/cycle).
REQ-011 SHALL hold rsp_y/rsp_zero/rsp_id stable while rsp_valid=1 and rsp_ready=0.
REQ-012 SHALL assert no reqN_ready while FULL and rsp_ready=0.
REQ-013 SHALL pass unknown control codes unchanged; the response is then whatever the ALU returns (y=0, zero=0), with no error flag.
REQ-014 SHALL keep a 1-bit last_grant register, updated on each grant to the index granted.
REQ-015 SHALL, when only one requester is valid, grant it regardless of last_grant.

Reset
REQ-016 SHALL, while resetn=0, asynchronously force rsp_valid=0, rsp_y=0, rsp_zero=0, rsp_id=0, last_grant=1.
REQ-017 SHALL hold req0_ready=req1_ready=0 and alu_a/alu_b/alu_control=0 throughout reset.
REQ-018 SHALL discard any in-flight or buffered response on reset mid-operation; the first grant after reset goes to req0 if both requesters are valid.

Configuration
REQ-019 SHALL honour macro CPU6_ALU_ARB_RR_EN:
- Defined: when both requesters are valid, grant the index != last_grant (round-robin).
- Undefined: req0 has fixed priority over req1, and last_grant is not implemented.

Verification
REQ-020 Add: req0 valid, a=5, b=7, control=010, rsp_ready=1 → req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_y=12, rsp_zero=0, rsp_id=0.
REQ-021 Sub: req1 a=9, b=9, control=110 → rsp_y=0, rsp_zero=1, rsp_id=1.
REQ-022 Both requesters valid for 4 cycles, rsp_ready=1:
- RR_EN defined → rsp_id sequence 0,1,0,1.
- Undefined → 0,0,0,0.
REQ-023 Backpressure: rsp_ready=0 for 3 cycles while FULL → both readys=0, rsp_y unchanged. Raising rsp_ready with a requester valid → drain and new grant in the same cycle, rsp_valid stays 1.
REQ-024 Control=111 from req0 → alu_control=111, rsp_y=0, rsp_zero=0. Idle cycles → alu_control=000.
REQ-025 resetn pulled low asynchronously while FULL → rsp_valid=0 immediately. After release, both valid → first rsp_id=0.
